// File: rtl/adc_audio_pkg.sv
// Shared constants, the stage-1 sample record and the output saturation helper
// for the ADC audio conditioner.
package adc_audio_pkg;
  localparam int ADC_MIDSCALE = 2048;
  localparam int ADC_W        = 12;
  localparam int AUDIO_W      = 8;
  localparam int AUDIO_CH     = 1;
  localparam int Y_W          = 14;
  localparam int SCALE_W      = 21;
  localparam int OUT_SHIFT    = 6;

  typedef struct packed {
    logic                  vld;
    logic signed [Y_W-1:0] y;
  } s1_t;

  // Take bits [13:6] of the scaled sample, clamping instead of wrapping.
  function automatic logic signed [AUDIO_W-1:0] sat_audio(input logic signed [SCALE_W-1:0] s);
    logic signed [SCALE_W-1:0] t;
    t = s >>> OUT_SHIFT;
    if (t > 21'sd127)       return 8'sh7F;
    else if (t < -21'sd128) return 8'sh80;
    else                    return t[AUDIO_W-1:0];
  endfunction
endpackage

// File: rtl/dc_blocker.sv
// Stage 1: offset-binary to signed conversion and first-order IIR DC removal.
// The DC tracker only moves on accepted samples, so it holds while disabled.
module dc_blocker import adc_audio_pkg::*; #(
  parameter int DC_SHIFT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept_i,
  input  logic [ADC_W-1:0] data_i,
  output s1_t              s1_o
);
  localparam int ACC_W = 13 + DC_SHIFT;

  logic signed [ACC_W-1:0] dc_acc_q, dc_acc_d;
  logic signed [12:0]      x, dc;
  logic signed [Y_W-1:0]   y_d, y_q;
  logic                    vld_q;

  always_comb begin
    x        = $signed({1'b0, data_i}) - $signed(13'(ADC_MIDSCALE));
    dc       = dc_acc_q[ACC_W-1:DC_SHIFT];
    y_d      = $signed({x[12], x}) - $signed({dc[12], dc});
    dc_acc_d = dc_acc_q + ACC_W'(y_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_acc_q <= '0;
      y_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= accept_i;
      if (accept_i) begin
        dc_acc_q <= dc_acc_d;
        y_q      <= y_d;
      end
    end
  end

  assign s1_o = '{vld: vld_q, y: y_q};
endmodule

// File: rtl/adc_audio_conditioner.sv
// ADC response stream to signed 8-bit audio: DC block, block-average decimation,
// shift gain with saturation and a stb/ack output. Optional VOX: ADC_AUDIO_VOX_EN.
module adc_audio_conditioner import adc_audio_pkg::*; #(
  parameter int AUDIO_CHANNEL = AUDIO_CH,
  parameter int DC_SHIFT      = 10,
  parameter int DECIM_LOG2    = 2
`ifdef ADC_AUDIO_VOX_EN
  , parameter int VOX_THRESH  = 16
  , parameter int VOX_HANG    = 4800
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [2:0]         gain,
  input  logic               response_valid,
  input  logic [4:0]         response_channel,
  input  logic [ADC_W-1:0]   response_data,
  output logic [AUDIO_W-1:0] audio_out,
  output logic               audio_out_stb,
  input  logic               audio_out_ack,
  output logic [15:0]        overrun_count
`ifdef ADC_AUDIO_VOX_EN
  , output logic             vox
`endif
);
  localparam int ACC_W = Y_W + DECIM_LOG2;

  logic accept;
  s1_t  s1;

  assign accept = response_valid && (response_channel == 5'(AUDIO_CHANNEL)) && enable;

  dc_blocker #(.DC_SHIFT(DC_SHIFT)) u_dc (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (accept),
    .data_i   (response_data),
    .s1_o     (s1)
  );

  // Stage 2: block average; the final sample is folded in combinationally
  logic signed [ACC_W-1:0]   acc_q, sum_d;
  logic [DECIM_LOG2-1:0]     cnt_q;
  logic signed [Y_W-1:0]     avg_q;
  logic                      rdy_q;

  assign sum_d = acc_q + ACC_W'(s1.y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      rdy_q <= 1'b0;
    end else if (!enable) begin
      acc_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else if (s1.vld) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) begin
        avg_q <= sum_d[ACC_W-1:DECIM_LOG2];
        acc_q <= '0;
        rdy_q <= 1'b1;
      end else begin
        acc_q <= sum_d;
        rdy_q <= 1'b0;
      end
    end else begin
      rdy_q <= 1'b0;
    end
  end

  // Stage 3: gain, saturation and the output handshake
  logic signed [SCALE_W-1:0] s_d;
  logic signed [AUDIO_W-1:0] audio_d, audio_q;
  logic                      stb_q;
  logic [15:0]               ovr_q;

  always_comb begin
    s_d     = $signed({{(SCALE_W-Y_W){avg_q[Y_W-1]}}, avg_q}) <<< gain;
    audio_d = sat_audio(s_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_q <= '0;
      stb_q   <= 1'b0;
      ovr_q   <= '0;
    end else if (rdy_q) begin
      audio_q <= audio_d;
      stb_q   <= 1'b1;
      if (stb_q && !audio_out_ack && (ovr_q != 16'hFFFF))
        ovr_q <= ovr_q + 16'd1;
    end else if (stb_q && audio_out_ack) begin
      stb_q <= 1'b0;
    end
  end

  assign audio_out     = audio_q;
  assign audio_out_stb = stb_q;
  assign overrun_count = ovr_q;

`ifdef ADC_AUDIO_VOX_EN
  // Hang time counts output samples, not clocks
  logic [AUDIO_W-1:0] mag_d;
  logic [15:0]        hang_q;
  logic               vox_q;

  assign mag_d = audio_d[AUDIO_W-1] ? AUDIO_W'(-audio_d) : audio_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hang_q <= '0;
      vox_q  <= 1'b0;
    end else if (rdy_q) begin
      if (int'(mag_d) >= VOX_THRESH) begin
        hang_q <= 16'(VOX_HANG);
        vox_q  <= 1'b1;
      end else if (hang_q != 16'd0) begin
        hang_q <= hang_q - 16'd1;
        if (hang_q == 16'd1) vox_q <= 1'b0;
      end
    end
  end

  assign vox = vox_q;
`endif
endmodule
